// File: rtl/axis_rx_pkg.sv
// axis_rx_pkg
// Shared constants for the AXI-Stream receiver:
//   ERR_STABLE     - bit of err flagging a beat that changed or vanished while stalled
//   ERR_KEEP_STRB  - bit of err flagging TSTRB asserted on a byte whose TKEEP is 0
//   ERR_W          - width of the sticky error vector
//   PKT_CNT_W      - width of the wrapping packet counter
package axis_rx_pkg;

    localparam int ERR_STABLE    = 0;
    localparam int ERR_KEEP_STRB = 1;
    localparam int ERR_W         = 2;
    localparam int PKT_CNT_W     = 16;

endpackage

// File: rtl/axis_rx_if.sv
// axis_if
// AXI-Stream signal bundle between an upstream transmitter and a receiver.
//   master modport : drives TVALID/TDATA/TKEEP/TSTRB/TLAST/TID/TDEST/TUSER, samples TREADY
//   slave modport  : samples the beat fields, drives TREADY
interface axis_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 8
);

    logic                     TVALID;
    logic                     TREADY;
    logic [TDATA_WIDTH-1:0]   TDATA;
    logic [TDATA_WIDTH/8-1:0] TKEEP;
    logic [TDATA_WIDTH/8-1:0] TSTRB;
    logic                     TLAST;
    logic [TID_WIDTH-1:0]     TID;
    logic [TDEST_WIDTH-1:0]   TDEST;
    logic [TUSER_WIDTH-1:0]   TUSER;

    modport master (
        output TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TKEEP, TSTRB, TLAST, TID, TDEST, TUSER,
        output TREADY
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo
// Generic synchronous first-word-fall-through FIFO.
//   clock, reset : rising-edge clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data/full  : write side; writes while full are dropped
//   rd_en/rd_data/empty : read side; rd_data shows the head entry (zero when empty),
//                         rd_en pops it, rd_en while empty is ignored
//   level               : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module axis_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     full,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic [LW-1:0]    count;
    logic             doWrite;
    logic             doRead;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign doWrite = wr_en && !full;
    assign doRead  = rd_en && !empty;

    // The head is read straight out of the array so a written entry is
    // visible the cycle after its write; it is forced to zero when empty so
    // stale contents never leak out after reset or a full drain.
    assign rd_data = empty ? '0 : mem[rdPtr];

    // Pointer and occupancy bookkeeping; a simultaneous write and read
    // leaves the count untouched.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doRead) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doWrite, doRead})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array is left out of reset; emptiness is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (doWrite) begin
            mem[wrPtr] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_receiver.sv
// axis_receiver
// AXI-Stream sink endpoint. Accepted beats are filtered (pure null beats are
// dropped), byte-masked by TKEEP and buffered in an FWFT FIFO that a local
// consumer pops. Also counts TLAST beats and keeps sticky protocol errors.
//   ACLK, ARESET      : clock, synchronous active-high reset
//   s_axis            : AXI-Stream slave side (TVALID..TUSER in, TREADY out)
//   rd_en             : pop request from the consumer
//   rd_valid, rd_*    : head entry of the buffer
//   level             : buffer occupancy
//   pkt_count         : accepted TLAST beats, wrapping
//   err, err_clr      : sticky stability / keep-strobe errors and their clear
module axis_receiver
    import axis_rx_pkg::*;
#(
    parameter int TDATA_WIDTH = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 8,
    parameter int DEPTH       = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    axis_if.slave                    s_axis,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [TDATA_WIDTH-1:0]   rd_data,
    output logic [TDATA_WIDTH/8-1:0] rd_keep,
    output logic                     rd_last,
    output logic [TID_WIDTH-1:0]     rd_id,
    output logic [TDEST_WIDTH-1:0]   rd_dest,
    output logic [TUSER_WIDTH-1:0]   rd_user,
    output logic [$clog2(DEPTH):0]   level,
    output logic [PKT_CNT_W-1:0]     pkt_count,
    output logic [ERR_W-1:0]         err,
    input  logic                     err_clr
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int WORD_W = TDATA_WIDTH + KEEP_W + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;
    localparam int BEAT_W = TDATA_WIDTH + 2 * KEEP_W + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

    logic                   readyArm;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   accept;
    logic                   wrEn;
    logic [TDATA_WIDTH-1:0] maskedData;
    logic [WORD_W-1:0]      wrWord;
    logic [WORD_W-1:0]      rdWord;
    logic [BEAT_W-1:0]      curBeat;
    logic [BEAT_W-1:0]      prevBeat;
    logic                   prevStall;
    logic [ERR_W-1:0]       newErr;

    // TREADY comes from registers only: readyArm holds it low for the first
    // cycle out of reset, and the FIFO full flag is itself registered state.
    assign s_axis.TREADY = readyArm && !fifoFull;
    assign accept        = s_axis.TVALID && s_axis.TREADY;

    // A beat with no valid bytes carries nothing unless it closes a packet,
    // in which case it is kept so the consumer still sees the boundary.
    assign wrEn = accept && ((|s_axis.TKEEP) || s_axis.TLAST);

    // Null bytes are stored as zero so downstream never sees garbage data.
    always_comb begin
        maskedData = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            if (s_axis.TKEEP[b]) begin
                maskedData[8*b +: 8] = s_axis.TDATA[8*b +: 8];
            end
        end
    end

    assign wrWord  = {maskedData, s_axis.TKEEP, s_axis.TLAST,
                      s_axis.TID, s_axis.TDEST, s_axis.TUSER};
    assign curBeat = {s_axis.TDATA, s_axis.TKEEP, s_axis.TSTRB, s_axis.TLAST,
                      s_axis.TID, s_axis.TDEST, s_axis.TUSER};

    axis_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (ACLK),
        .reset   (ARESET),
        .wr_en   (wrEn),
        .wr_data (wrWord),
        .full    (fifoFull),
        .rd_en   (rd_en),
        .rd_data (rdWord),
        .empty   (fifoEmpty),
        .level   (level)
    );

    assign rd_valid = !fifoEmpty;
    assign {rd_data, rd_keep, rd_last, rd_id, rd_dest, rd_user} = rdWord;

    // Protocol checks. A stalled beat (valid without ready) must be held
    // unchanged until it is taken; TSTRB may only mark bytes that TKEEP keeps.
    always_comb begin
        newErr                = '0;
        newErr[ERR_STABLE]    = prevStall && (!s_axis.TVALID || (curBeat != prevBeat));
        newErr[ERR_KEEP_STRB] = s_axis.TVALID && (|(s_axis.TSTRB & ~s_axis.TKEEP));
    end

    // Ready arming, packet counting, sticky errors and stall tracking. A new
    // error in the same cycle as err_clr stays set. Clearing prevStall on
    // reset keeps the checker quiet in the first cycle afterwards.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            readyArm  <= 1'b0;
            pkt_count <= '0;
            err       <= '0;
            prevStall <= 1'b0;
            prevBeat  <= '0;
        end else begin
            readyArm <= 1'b1;
            if (accept && s_axis.TLAST) begin
                pkt_count <= pkt_count + 1'b1;
            end
            err       <= (err & ~{ERR_W{err_clr}}) | newErr;
            prevStall <= s_axis.TVALID && !s_axis.TREADY;
            prevBeat  <= curBeat;
        end
    end

endmodule
